// File: rtl/mem8_arb_pkg.sv
// ============================================================================
// mem8_arb_pkg : shared state type and default sizes for the byte-memory arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package mem8_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    XFER  = 3'd2,
    TAIL  = 3'd3,
    FIN   = 3'd4
  } arb_state_t;

  localparam int ARB_SLICE_DEF = 8;
  localparam int ARB_LW_DEF    = 12;

endpackage

`default_nettype wire

// File: rtl/arb_burst_ctr.sv
// ============================================================================
// arb_burst_ctr : host burst address / remaining-length counters with last flag
// Revision 1.0
// ============================================================================
`default_nettype none

module arb_burst_ctr #(
  parameter int ASZ = 17,
  parameter int LW  = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [ASZ-1:0] addr_in,
  input  logic [LW-1:0]  len_in,
  input  logic           step,
  output logic [ASZ-1:0] ha,
  output logic           last
);

  logic [LW-1:0] hcnt;

  // ha wraps naturally at 2^ASZ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ha   <= '0;
      hcnt <= '0;
    end else if (load) begin
      ha   <= addr_in;
      hcnt <= len_in;
    end else if (step) begin
      ha   <= ha + 1'b1;
      hcnt <= hcnt - 1'b1;
    end
  end

  assign last = (hcnt == LW'(1));

endmodule

`default_nettype wire

// File: rtl/mem8_arb.sv
// ============================================================================
// mem8_arb : shares the 8-bit SPRAM between the core and a host DMA burst port.
// Optional fair slicing of host bursts: define MEM8_ARB_FAIR_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module mem8_arb
  import mem8_arb_pkg::*;
#(
  parameter int ASZ   = 17,
  parameter int LW    = ARB_LW_DEF,
  parameter int SLICE = ARB_SLICE_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [ASZ-1:0] cpu_addr,
  input  logic           cpu_we,
  input  logic [7:0]     cpu_wdata,
  output logic [7:0]     cpu_rdata,
  output logic           cpu_stall,
  input  logic           h_start,
  input  logic           h_we,
  input  logic [ASZ-1:0] h_addr,
  input  logic [LW-1:0]  h_len,
  input  logic [7:0]     h_wdata,
  input  logic           h_wvalid,
  output logic           h_wready,
  output logic [7:0]     h_rdata,
  output logic           h_rvalid,
  output logic           h_busy,
  output logic           h_done,
  output logic [ASZ-1:0] m_addr,
  output logic           m_we,
  output logic [7:0]     m_wdata,
  input  logic [7:0]     m_rdata
);

`ifdef MEM8_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  localparam int SW = $clog2(SLICE + 1);

  arb_state_t     state;
  logic           hwe;
  logic           rvalid_q;
  logic [SW-1:0]  slice_cnt;
  logic [ASZ-1:0] ha;
  logic           last;
  logic           load;
  logic           core_slot;
  logic           host_slot;
  logic           core_owns;
  logic           step;

  assign load      = (state == IDLE) && h_start;
  assign core_slot = FAIR && (state == XFER) && (slice_cnt == SW'(SLICE));
  assign host_slot = (state == XFER) && !core_slot;
  assign core_owns = (state == IDLE) || (state == FIN) || core_slot;
  assign step      = host_slot && (!hwe || h_wvalid);

  arb_burst_ctr #(
    .ASZ (ASZ),
    .LW  (LW)
  ) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .addr_in (h_addr),
    .len_in  (h_len),
    .step    (step),
    .ha      (ha),
    .last    (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hwe      <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= host_slot && !hwe;
      case (state)
        IDLE: begin
          if (h_start) begin
            hwe   <= h_we;
            state <= (h_len != '0) ? DRAIN : FIN;
          end
        end
        DRAIN:   state <= XFER;
        XFER: begin
          // reads need one more cycle for the final byte to return
          if (step && last) state <= hwe ? FIN : TAIL;
        end
        TAIL:    state <= FIN;
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // counts consecutive host slots; constant-folds away when slicing is off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slice_cnt <= '0;
    end else if ((state != XFER) || core_slot) begin
      slice_cnt <= '0;
    end else begin
      slice_cnt <= slice_cnt + 1'b1;
    end
  end

  always_comb begin
    m_addr  = cpu_addr;
    m_wdata = cpu_wdata;
    m_we    = core_owns && cpu_we;
    if (host_slot) begin
      m_addr  = ha;
      m_wdata = h_wdata;
      m_we    = hwe && h_wvalid;
    end
  end

  assign cpu_rdata = m_rdata;
  assign cpu_stall = ((state == DRAIN) || (state == XFER) || (state == TAIL)) && !core_slot;
  assign h_wready  = host_slot && hwe;
  assign h_rvalid  = rvalid_q;
  assign h_rdata   = rvalid_q ? m_rdata : 8'h00;
  assign h_busy    = (state != IDLE);
  assign h_done    = (state == FIN);

endmodule

`default_nettype wire

// File: tb/tb_mem8_arb.sv
// ============================================================================
// tb_mem8_arb : randomized self-checking bench with SPRAM and reference memory
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem8_arb;

  localparam int ASZ   = 17;
  localparam int LW    = 12;
  localparam int SLICE = 8;
`ifdef MEM8_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [ASZ-1:0] cpu_addr = '0;
  logic           cpu_we = 1'b0;
  logic [7:0]     cpu_wdata = '0;
  logic [7:0]     cpu_rdata;
  logic           cpu_stall;
  logic           h_start = 1'b0;
  logic           h_we = 1'b0;
  logic [ASZ-1:0] h_addr = '0;
  logic [LW-1:0]  h_len = '0;
  logic [7:0]     h_wdata = '0;
  logic           h_wvalid = 1'b0;
  logic           h_wready;
  logic [7:0]     h_rdata;
  logic           h_rvalid;
  logic           h_busy;
  logic           h_done;
  logic [ASZ-1:0] m_addr;
  logic           m_we;
  logic [7:0]     m_wdata;
  logic [7:0]     m_rdata;

  int checks = 0;
  int errors = 0;

  mem8_arb #(.ASZ(ASZ), .LW(LW), .SLICE(SLICE)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .h_start(h_start), .h_we(h_we), .h_addr(h_addr), .h_len(h_len),
    .h_wdata(h_wdata), .h_wvalid(h_wvalid), .h_wready(h_wready),
    .h_rdata(h_rdata), .h_rvalid(h_rvalid), .h_busy(h_busy), .h_done(h_done),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37) ^ (i >> 7));
  endfunction

  // SPRAM behaviour: synchronous write, one-cycle read latency
  logic [7:0] sram [0:(1<<ASZ)-1];
  logic [7:0] ref_mem [0:(1<<ASZ)-1];
  logic       mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < (1 << ASZ); i++) sram[i] <= init_byte(i);
      mem_ready <= 1'b1;
    end else begin
      if (m_we) sram[m_addr] <= m_wdata;
      m_rdata <= sram[m_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read burst against the reference memory; host slot k lands at cycle 2+k plus
  // one core slot for every SLICE host slots already taken in fair mode.
  task automatic do_read(input logic [ASZ-1:0] addr, input int len, input bit core_we);
    int got, last_c, done_exp, rv_exp;
    bit core, exp_stall;
    logic [ASZ-1:0] a;
    got = 0;
    last_c = 2 + (len - 1) + (FAIR ? (len - 1) / SLICE : 0);
    done_exp = last_c + 2;
    h_we = 1'b0; h_addr = addr; h_len = LW'(len); h_start = 1'b1;
    tick();
    h_start = 1'b0;
    cpu_we = core_we;
    #1;
    for (int cyc = 1; cyc <= done_exp + 2; cyc++) begin
      core = FAIR && (cyc >= 2) && (cyc <= last_c) && (((cyc - 2) % (SLICE + 1)) == SLICE);
      exp_stall = (cyc < done_exp) && !core;
      checks++;
      if (cpu_stall !== exp_stall) begin
        errors++; $display("FAIL rd_stall cyc %0d got %b exp %b", cyc, cpu_stall, exp_stall);
      end
      if (exp_stall) begin
        checks++;
        if (m_we !== 1'b0) begin
          errors++; $display("FAIL rd_no_write cyc %0d got m_we %b exp 0", cyc, m_we);
        end
      end
      if (core) begin
        checks++;
        if (m_we !== cpu_we || m_addr !== cpu_addr) begin
          errors++; $display("FAIL core_slot cyc %0d got we %b addr %h exp we %b addr %h",
                             cyc, m_we, m_addr, cpu_we, cpu_addr);
        end
      end
      if (h_rvalid === 1'b1) begin
        if (got < len) begin
          a = addr + ASZ'(got);
          rv_exp = 3 + got + (FAIR ? got / SLICE : 0);
          checks++;
          if (h_rdata !== ref_mem[a] || cyc != rv_exp) begin
            errors++; $display("FAIL rd_data byte %0d got %h@%0d exp %h@%0d",
                               got, h_rdata, cyc, ref_mem[a], rv_exp);
          end
        end
        got++;
      end
      checks++;
      if (h_done !== (cyc == done_exp) || h_busy !== (cyc <= done_exp)) begin
        errors++; $display("FAIL rd_done cyc %0d got done %b busy %b exp done at %0d",
                           cyc, h_done, h_busy, done_exp);
      end
      tick();
    end
    if (core_we) ref_mem[cpu_addr] = cpu_wdata;
    cpu_we = 1'b0;
    checks++;
    if (got != len) begin
      errors++; $display("FAIL rd_count got %0d exp %0d", got, len);
    end
  endtask

  // Write burst; mask bit i gives h_wvalid in the i-th cycle after DRAIN.
  task automatic do_write(input logic [ASZ-1:0] addr, input int len,
                          input logic [31:0] mask, input int base);
    logic [7:0] d[$];
    int idx, done_cyc, last_acc, cyc;
    logic [ASZ-1:0] a;
    for (int i = 0; i < len; i++) d.push_back((base < 0) ? 8'($urandom) : 8'(base + i));
    idx = 0; done_cyc = -1; last_acc = -1; cyc = 1;
    h_we = 1'b1; h_addr = addr; h_len = LW'(len); h_start = 1'b1;
    tick();
    h_start = 1'b0;
    while (cyc < 4 * len + 40 && done_cyc < 0) begin
      h_wvalid = (idx < len) && (cyc >= 2) && ((cyc - 2 >= 32) || mask[cyc - 2]);
      h_wdata  = (idx < len) ? d[idx] : 8'($urandom);
      #1;
      if (cyc <= 2) begin
        checks++;
        if (h_wready !== (cyc == 2)) begin
          errors++; $display("FAIL wr_ready cyc %0d got %b exp %b", cyc, h_wready, cyc == 2);
        end
      end
      a = addr + ASZ'(idx);
      checks++;
      if (h_wready === 1'b1 && h_wvalid) begin
        if (m_we !== 1'b1 || m_addr !== a || m_wdata !== d[idx]) begin
          errors++; $display("FAIL wr_beat %0d got we %b addr %h data %h exp 1 %h %h",
                             idx, m_we, m_addr, m_wdata, a, d[idx]);
        end
        idx++;
        last_acc = cyc;
      end else if (m_we !== 1'b0) begin
        errors++; $display("FAIL wr_idle cyc %0d got m_we %b exp 0", cyc, m_we);
      end
      if (h_done === 1'b1) done_cyc = cyc;
      tick();
      cyc++;
    end
    h_wvalid = 1'b0; h_we = 1'b0;
    for (int i = 0; i < len; i++) begin
      a = addr + ASZ'(i);
      ref_mem[a] = d[i];
    end
    checks++;
    if (idx != len || done_cyc != last_acc + 1) begin
      errors++; $display("FAIL wr_done got beats %0d done %0d exp beats %0d done %0d",
                         idx, done_cyc, len, last_acc + 1);
    end
  endtask

  task automatic test_reset();
    cpu_addr = 17'h0ABCD; cpu_wdata = 8'h5A; cpu_we = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b0 || h_busy !== 1'b0 || h_done !== 1'b0 || h_rvalid !== 1'b0 ||
        h_wready !== 1'b0 || m_addr !== cpu_addr || m_we !== 1'b1 || m_wdata !== 8'h5A) begin
      errors++; $display("FAIL reset got stall %b busy %b done %b rv %b wr %b m %h/%b/%h exp 0s and %h/1/5a",
                         cpu_stall, h_busy, h_done, h_rvalid, h_wready, m_addr, m_we, m_wdata, cpu_addr);
    end
    cpu_we = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_idle_pass();
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 17'h01000 + 17'(i); cpu_we = 1'b1; cpu_wdata = 8'h31 + 8'(i);
      #1;
      checks++;
      if (m_addr !== cpu_addr || m_we !== 1'b1 || m_wdata !== cpu_wdata || cpu_stall !== 1'b0) begin
        errors++; $display("FAIL idle_pass got %h/%b/%h stall %b exp %h/1/%h 0",
                           m_addr, m_we, m_wdata, cpu_stall, cpu_addr, cpu_wdata);
      end
      ref_mem[cpu_addr] = cpu_wdata;
      tick();
    end
    cpu_we = 1'b0; cpu_addr = 17'h01002;
    tick();
    checks++;
    if (cpu_rdata !== 8'h33) begin
      errors++; $display("FAIL cpu_read got %h exp 33", cpu_rdata);
    end
    cpu_addr = 17'h00400;
  endtask

  task automatic test_read_burst();
    do_read(17'h01000, 4, 1'b0);
  endtask

  task automatic test_write_gap();
    do_write(17'h01400, 3, 32'hFFFF_FFFD, 8'h41);
    tick();
    checks++;
    if (sram[17'h01400] !== 8'h41 || sram[17'h01401] !== 8'h42 || sram[17'h01402] !== 8'h43) begin
      errors++; $display("FAIL wr_gap_mem got %h %h %h exp 41 42 43",
                         sram[17'h01400], sram[17'h01401], sram[17'h01402]);
    end
    do_read(17'h01400, 3, 1'b0);
  endtask

  task automatic test_wrap();
    logic [7:0] keep;
    keep = ref_mem[2];
    do_write(17'h1FFFE, 4, 32'hFFFF_FFFF, -1);
    tick();
    checks++;
    if (sram[17'h1FFFE] !== ref_mem[17'h1FFFE] || sram[17'h1FFFF] !== ref_mem[17'h1FFFF] ||
        sram[0] !== ref_mem[0] || sram[1] !== ref_mem[1] || sram[2] !== keep) begin
      errors++; $display("FAIL wrap got %h %h %h %h %h exp %h %h %h %h %h",
                         sram[17'h1FFFE], sram[17'h1FFFF], sram[0], sram[1], sram[2],
                         ref_mem[17'h1FFFE], ref_mem[17'h1FFFF], ref_mem[0], ref_mem[1], keep);
    end
    do_read(17'h1FFFE, 4, 1'b0);
  endtask

  task automatic test_zero_len();
    h_we = 1'b0; h_addr = 17'h00777; h_len = '0; h_start = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b0 || h_done !== 1'b0) begin
      errors++; $display("FAIL zero_c0 got stall %b done %b exp 0 0", cpu_stall, h_done);
    end
    tick();
    h_start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (h_done !== (c == 1) || cpu_stall !== 1'b0 || h_rvalid !== 1'b0) begin
        errors++; $display("FAIL zero_len cyc %0d got done %b stall %b rv %b exp %b 0 0",
                           c, h_done, cpu_stall, h_rvalid, c == 1);
      end
      tick();
    end
  endtask

  task automatic test_busy_ignore();
    int dones, rv;
    dones = 0; rv = 0;
    h_we = 1'b0; h_addr = 17'h01000; h_len = 12'd4; h_start = 1'b1;
    tick();
    for (int c = 1; c <= 12; c++) begin
      if (c == 2 || c == 5) begin
        h_start = 1'b1; h_len = 12'd5; h_addr = 17'h03000; h_we = 1'b1;
      end else begin
        h_start = 1'b0;
      end
      #1;
      if (h_done === 1'b1) dones++;
      if (h_rvalid === 1'b1) rv++;
      tick();
    end
    h_start = 1'b0; h_we = 1'b0;
    checks++;
    if (dones != 1 || rv != 4) begin
      errors++; $display("FAIL busy_ignore got dones %0d rvalids %0d exp 1 4", dones, rv);
    end
  endtask

  task automatic test_fair_core();
    cpu_addr = 17'h00055; cpu_wdata = 8'hA5;
    do_read(17'h02000, 20, 1'b1);
    tick();
    checks++;
    if (sram[17'h00055] !== 8'hA5) begin
      errors++; $display("FAIL core_commit got %h exp a5", sram[17'h00055]);
    end
    cpu_addr = 17'h00400;
  endtask

  task automatic test_reset_mid();
    h_we = 1'b0; h_addr = 17'h05000; h_len = 12'd10; h_start = 1'b1;
    tick();
    h_start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b0 || h_busy !== 1'b0 || h_done !== 1'b0 || h_rvalid !== 1'b0 ||
        h_wready !== 1'b0 || m_we !== 1'b0 || m_addr !== cpu_addr) begin
      errors++; $display("FAIL rst_mid got stall %b busy %b done %b rv %b we %b exp all 0",
                         cpu_stall, h_busy, h_done, h_rvalid, m_we);
    end
    for (int c = 0; c < 6; c++) begin
      if (c == 2) rst = 1'b0;
      tick();
      checks++;
      if (h_done !== 1'b0 || h_busy !== 1'b0) begin
        errors++; $display("FAIL rst_no_done cyc %0d got done %b busy %b exp 0 0", c, h_done, h_busy);
      end
    end
    do_read(17'h05000, 2, 1'b0);
  endtask

  task automatic test_random();
    logic [ASZ-1:0] a;
    int len;
    for (int n = 0; n < 8; n++) begin
      a = ASZ'($urandom);
      len = 1 + int'($urandom_range(0, 39));
      if (n % 2 == 0) do_write(a, len, $urandom | $urandom, -1);
      else do_read(a, len, 1'b0);
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ASZ); i++) ref_mem[i] = init_byte(i);
    repeat (2) tick();
    test_reset();
    test_idle_pass();
    test_read_burst();
    test_write_gap();
    test_wrap();
    test_zero_len();
    test_busy_ignore();
    test_fair_core();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem8_arb.md
# mem8_arb

Byte-memory arbiter that shares the single-port 8-bit SPRAM between the eJ32 core and a host DMA port. The host uses the DMA port to preload the TIB, drain OBUF and dump memory while the core runs. The arbiter stalls the core during host bursts and runs the burst address and length counters. It sits between the core/host and the `mb8_io` master side.

## Interface
Parameters:
- `ASZ`, 17, byte address width (128K).
- `LW`, 12, burst length width; maximum burst is 2^LW−1 bytes.
- `SLICE`, 8, maximum consecutive host slots before one core slot (fair mode only).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_addr`  in  ASZ  core byte address.
- `cpu_we`  in  1  core write strobe.
- `cpu_wdata`  in  8  core write data.
- `cpu_rdata`  out  8  memory read data to the core (pass-through of `m_rdata`).
- `cpu_stall`  out  1  core must hold its state this cycle.
- `h_start`  in  1  one-cycle burst request.
- `h_we`  in  1  burst direction: 1 = write, 0 = read. Sampled at `h_start`.
- `h_addr`  in  ASZ  burst start address. Sampled at `h_start`.
- `h_len`  in  LW  burst byte count. Sampled at `h_start`.
- `h_wdata`  in  8  write byte.
- `h_wvalid`  in  1  `h_wdata` is valid.
- `h_wready`  out  1  arbiter accepts the write byte this cycle.
- `h_rdata`  out  8  read byte.
- `h_rvalid`  out  1  `h_rdata` is valid.
- `h_busy`  out  1  a burst is in progress.
- `h_done`  out  1  one-cycle burst-complete pulse.
- `m_addr`  out  ASZ  SPRAM address.
- `m_we`  out  1  SPRAM write enable.
- `m_wdata`  out  8  SPRAM write data.
- `m_rdata`  in  8  SPRAM read data; valid one clk after the address is presented.

## Operation
- States and transitions:
  - IDLE → DRAIN when `h_start` is sampled and `h_len`≠0.
  - IDLE → FIN when `h_start` is sampled and `h_len`==0.
  - DRAIN → XFER after one cycle.
  - XFER → TAIL on the last read address issued.
  - XFER → FIN on the last write byte accepted.
  - TAIL → FIN after one cycle.
  - FIN → IDLE after one cycle.
- Start sampling: `h_start` is ignored outside IDLE. On acceptance, address, length and direction are latched into `ha` (ASZ), `hcnt` (LW) and `hwe`.
- IDLE behaviour: the memory port follows the core, so `m_addr`/`m_we`/`m_wdata` equal the `cpu_*` inputs; `cpu_stall`=0.
- DRAIN behaviour: the core keeps its current cycle, letting any in-flight core read complete; `cpu_stall`=1 from this cycle through TAIL.
- XFER, read burst:
  - Each host slot drives `m_addr`=`ha` with `m_we`=0, then increments `ha` and decrements `hcnt`.
  - `h_rvalid` pulses the following cycle with `h_rdata`=`m_rdata`.
- XFER, write burst:
  - `h_wready`=1 in host slots.
  - When `h_wvalid`&&`h_wready`, drive `m_we`=1, `m_addr`=`ha`, `m_wdata`=`h_wdata`, then increment `ha` and decrement `hcnt`.
  - A slot without `h_wvalid` is an idle slot; nothing advances.
- `ha` wraps modulo 2^ASZ (0x1FFFF+1 → 0).
- FIN: `h_done`=1 for one cycle and `h_busy` falls. `h_busy` is high from DRAIN through FIN.
- Reset: state=IDLE, counters 0. Every output is 0 except the pass-through signals (`cpu_rdata`, and `m_addr`/`m_we`/`m_wdata` following `cpu_*`). Reset mid-burst aborts the burst; no `h_done` is produced.

## Timing
- `h_start` sampled at cycle 0 gives DRAIN at cycle 1 and the first host slot at cycle 2.
- For an N-byte read without core slots, the last `h_rvalid` is at cycle N+2 and `h_done` at cycle N+3.
- Zero-length request: `h_done` at cycle 1; `cpu_stall` never rises.
- For write bursts, throughput is one byte per cycle while `h_wvalid` is held.
- All state outputs are registered or decoded from registered state. The only combinational paths are `cpu_*`→`m_*` in IDLE and core slots, and `m_rdata`→`cpu_rdata`/`h_rdata`.

## Configuration
- `MEM8_ARB_FAIR_EN` defined:
  - After `SLICE` consecutive host slots in XFER, the next cycle is a core slot: `cpu_stall`=0, the memory follows the core, `h_wready`=0 and no host address is issued.
  - The slice counter restarts after the core slot.
  - A read's `h_rvalid` may therefore show a gap.
- Undefined: the host owns every XFER cycle until the burst ends.

## Structure
- Shared package `mem8_arb_pkg` holds:
  - typedef `arb_state_t` {IDLE, DRAIN, XFER, TAIL, FIN};
  - constants `ARB_SLICE_DEF`=8 and `ARB_LW_DEF`=12.
- Sub-module `arb_burst_ctr` contains the `ha`/`hcnt` load, increment/decrement and last-byte flag. It is instantiated once.

## Test plan
- Read burst: `h_addr`=0x1000, `h_len`=4, memory 0x1000..3 = 31 32 33 34 → `h_rvalid` at cycles 3–6 carrying 31,32,33,34; `h_done` at cycle 7; `cpu_stall` high for cycles 1–6.
- Write burst: `h_addr`=0x1400, `h_len`=3, `h_wdata` 0x41,0x42,0x43 with `h_wvalid` dropped for one cycle in the middle → after `h_done`, a read-back returns 41 42 43; the gap cycle shows `m_we`=0.
- Wrap: `h_addr`=0x1FFFE, `h_len`=4, write → bytes land at 0x1FFFE, 0x1FFFF, 0x0, 0x1.
- Zero-length and while-busy requests: `h_len`=0 → `h_done` one cycle later with `cpu_stall` never high. A second `h_start` during a 4-byte burst is ignored, yielding exactly one `h_done`.
- Fair mode (`MEM8_ARB_FAIR_EN`, `SLICE`=8), 20-byte read → `cpu_stall` low at XFER cycles 9 and 18; all 20 bytes are returned in order and the core's write in its slot commits.
- Reset mid-burst: assert `rst` during byte 2 of a 10-byte read → all outputs 0 immediately and no `h_done`; after release, a new 2-byte burst completes normally.
